// File: rtl/link_pkg.sv
// Shared types and helpers for link statistics blocks.
package link_pkg;

  typedef enum logic [1:0] {
    WD_IDLE  = 2'd0,
    WD_INPKT = 2'd1,
    WD_HUNG  = 2'd2
  } wd_fsm_t;

  localparam int unsigned SAT_W = 32;

  // Saturating increment for counters of any width up to SAT_W bits.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] cnt,
                                                input int unsigned      width);
    logic [SAT_W-1:0] max_v;
    if (width >= SAT_W) begin
      max_v = {SAT_W{1'b1}};
    end else begin
      max_v = (32'd1 << width) - 32'd1;
    end
    if (cnt >= max_v) begin
      sat_inc = max_v;
    end else begin
      sat_inc = cnt + 32'd1;
    end
  endfunction

endpackage

// File: rtl/link_watchdog.sv
// Passive link monitor: tracks packet framing and raises a sticky alarm when an
// intra-packet gap reaches THRESHOLD cycles. Link signals pass straight through.
module link_watchdog
  import link_pkg::*;
#(
  parameter logic [15:0] ADDRESS   = 16'h0000,
  parameter string       PORT      = "",
  parameter int unsigned THRESHOLD = 64,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tx_i,
  input  logic             eop_tx_i,
  output logic             cr_tx_o,
  output logic             rx_o,
  output logic             eop_rx_o,
  input  logic             cr_rx_i,
  output logic             alarm_o,
  input  logic             alarm_clr_i,
  output logic [CNT_W-1:0] pkt_cnt_o,
  output logic [CNT_W-1:0] hang_cnt_o,
  output logic [CNT_W-1:0] max_gap_o
);

  localparam logic [CNT_W-1:0] THR_C = CNT_W'(THRESHOLD);

  wd_fsm_t          state_r, state_nxt_s;
  logic [CNT_W-1:0] gap_r, gap_nxt_s, gap_inc_s;
  logic [CNT_W-1:0] pkt_cnt_r, hang_cnt_r, max_gap_r;
  logic             alarm_r;
  logic             xfer_s, gap_cyc_s;
  logic             pkt_inc_s, hang_set_s, gap_close_s;

  assign cr_tx_o  = cr_rx_i;
  assign rx_o     = tx_i;
  assign eop_rx_o = eop_tx_i;

  assign xfer_s    = tx_i & cr_rx_i;
  assign gap_cyc_s = ~tx_i & cr_rx_i;
  assign gap_inc_s = CNT_W'(sat_inc(32'(gap_r), CNT_W));

  // Framing FSM next-state and gap tracking; back-pressure holds the gap count.
  always_comb begin
    state_nxt_s = state_r;
    gap_nxt_s   = gap_r;
    pkt_inc_s   = 1'b0;
    hang_set_s  = 1'b0;
    gap_close_s = 1'b0;
    case (state_r)
      WD_IDLE: begin
        if (xfer_s) begin
          gap_nxt_s = {CNT_W{1'b0}};
          if (eop_tx_i) begin
            pkt_inc_s   = 1'b1;
            state_nxt_s = WD_IDLE;
          end else begin
            state_nxt_s = WD_INPKT;
          end
        end else begin
          state_nxt_s = WD_IDLE;
        end
      end
      WD_INPKT, WD_HUNG: begin
        if (xfer_s) begin
          gap_close_s = 1'b1;
          gap_nxt_s   = {CNT_W{1'b0}};
          if (eop_tx_i) begin
            pkt_inc_s   = 1'b1;
            state_nxt_s = WD_IDLE;
          end else begin
            state_nxt_s = WD_INPKT;
          end
        end else if (gap_cyc_s) begin
          gap_nxt_s = gap_inc_s;
          // Only the first crossing within a gap raises an event; HUNG just keeps counting.
          if ((state_r == WD_INPKT) && (gap_inc_s == THR_C)) begin
            hang_set_s  = 1'b1;
            state_nxt_s = WD_HUNG;
          end else begin
            state_nxt_s = state_r;
          end
        end else begin
          gap_nxt_s = gap_r;
        end
      end
      default: begin
        state_nxt_s = WD_IDLE;
        gap_nxt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // FSM state and current gap length.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= WD_IDLE;
      gap_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      gap_r   <= gap_nxt_s;
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pkt_cnt_r  <= {CNT_W{1'b0}};
      hang_cnt_r <= {CNT_W{1'b0}};
      max_gap_r  <= {CNT_W{1'b0}};
    end else begin
      if (pkt_inc_s) begin
        pkt_cnt_r <= CNT_W'(sat_inc(32'(pkt_cnt_r), CNT_W));
      end
      if (hang_set_s) begin
        hang_cnt_r <= CNT_W'(sat_inc(32'(hang_cnt_r), CNT_W));
      end
      if (gap_close_s && (gap_r > max_gap_r)) begin
        max_gap_r <= gap_r;
      end
    end
  end

  // Sticky alarm; a new hang event takes priority over a coincident clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      alarm_r <= 1'b0;
    end else if (hang_set_s) begin
      alarm_r <= 1'b1;
    end else if (alarm_clr_i) begin
      alarm_r <= 1'b0;
    end
  end

`ifndef SYNTHESIS
  // Simulation trace of hang events.
  always_ff @(posedge clk_i) begin
    if (!rst_i && hang_set_s) begin
      $display("WD [RS %02dx%02d-%s] hang detected", ADDRESS[15:8], ADDRESS[7:0], PORT);
    end
  end
`endif

  assign alarm_o    = alarm_r;
  assign pkt_cnt_o  = pkt_cnt_r;
  assign hang_cnt_o = hang_cnt_r;
  assign max_gap_o  = max_gap_r;

endmodule

// File: tb/tb_link_watchdog.sv
// Directed self-checking bench: THRESHOLD=8 with 16-bit and 4-bit counter instances.
module tb_link_watchdog;
  import link_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic        rst = 1'b1, tx = 1'b0, eop = 1'b0, cr = 1'b0, clr = 1'b0;
  logic        cr_tx, rx, eop_rx, alarm;
  logic [15:0] pkt_cnt, hang_cnt, max_gap;

  logic        rst4 = 1'b1, tx4 = 1'b0, eop4 = 1'b0, cr4 = 1'b0, clr4 = 1'b0;
  logic        cr_tx4, rx4, eop_rx4, alarm4;
  logic [3:0]  pkt_cnt4, hang_cnt4, max_gap4;

  link_watchdog #(.ADDRESS(16'h0102), .PORT("E"), .THRESHOLD(8), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .tx_i(tx), .eop_tx_i(eop), .cr_tx_o(cr_tx),
    .rx_o(rx), .eop_rx_o(eop_rx), .cr_rx_i(cr), .alarm_o(alarm),
    .alarm_clr_i(clr), .pkt_cnt_o(pkt_cnt), .hang_cnt_o(hang_cnt), .max_gap_o(max_gap)
  );

  link_watchdog #(.ADDRESS(16'h0304), .PORT("W"), .THRESHOLD(8), .CNT_W(4)) dut4 (
    .clk_i(clk), .rst_i(rst4), .tx_i(tx4), .eop_tx_i(eop4), .cr_tx_o(cr_tx4),
    .rx_o(rx4), .eop_rx_o(eop_rx4), .cr_rx_i(cr4), .alarm_o(alarm4),
    .alarm_clr_i(clr4), .pkt_cnt_o(pkt_cnt4), .hang_cnt_o(hang_cnt4), .max_gap_o(max_gap4)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic t, input logic e, input logic c);
    tx = t; eop = e; cr = c;
    @(posedge clk); #1;
  endtask

  task automatic cyc4(input logic t, input logic e, input logic c);
    tx4 = t; eop4 = e; cr4 = c;
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state and passthrough while in reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_alarm", {15'd0, alarm}, 16'd0);
    chk("rst_pkt", pkt_cnt, 16'd0);
    chk("rst_hang", hang_cnt, 16'd0);
    chk("rst_maxgap", max_gap, 16'd0);
    tx = 1'b1; eop = 1'b1; cr = 1'b0; #1;
    chk("pass_rx", {15'd0, rx}, 16'd1);
    chk("pass_eop", {15'd0, eop_rx}, 16'd1);
    chk("pass_cr", {15'd0, cr_tx}, 16'd0);
    tx = 1'b0; eop = 1'b0; cr = 1'b1; #1;
    chk("pass_cr1", {15'd0, cr_tx}, 16'd1);
    chk("pass_rx0", {15'd0, rx}, 16'd0);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b1);

    // 1: three-flit packet, no gaps
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    chk("t1_pkt", pkt_cnt, 16'd1);
    chk("t1_maxgap", max_gap, 16'd0);
    chk("t1_alarm", {15'd0, alarm}, 16'd0);

    // 2: single-flit packet, then idle gaps must not count
    cyc(1'b1, 1'b1, 1'b1);
    chk("t2_pkt", pkt_cnt, 16'd2);
    chk("t2_state", {14'd0, dut.state_r}, {14'd0, WD_IDLE});
    repeat (12) cyc(1'b0, 1'b0, 1'b1);
    chk("t2_idle_alarm", {15'd0, alarm}, 16'd0);

    // 3: 7-gap packet then 8-gap packet
    cyc(1'b1, 1'b0, 1'b1);
    repeat (7) cyc(1'b0, 1'b0, 1'b1);
    chk("t3_maxgap_open", max_gap, 16'd0);
    cyc(1'b1, 1'b1, 1'b1);
    chk("t3_alarm7", {15'd0, alarm}, 16'd0);
    chk("t3_maxgap7", max_gap, 16'd7);
    chk("t3_pkt7", pkt_cnt, 16'd3);
    cyc(1'b1, 1'b0, 1'b1);
    repeat (7) cyc(1'b0, 1'b0, 1'b1);
    chk("t3_alarm_g7", {15'd0, alarm}, 16'd0);
    cyc(1'b0, 1'b0, 1'b1);
    chk("t3_alarm_g8", {15'd0, alarm}, 16'd1);
    chk("t3_hang", hang_cnt, 16'd1);
    cyc(1'b1, 1'b1, 1'b1);
    chk("t3_maxgap8", max_gap, 16'd8);
    chk("t3_pkt8", pkt_cnt, 16'd4);

    // 5: clear, then clear coinciding with a new trigger
    clr = 1'b1; cyc(1'b0, 1'b0, 1'b1); clr = 1'b0;
    chk("t5_clr", {15'd0, alarm}, 16'd0);
    chk("t5_clr_hang", hang_cnt, 16'd1);
    chk("t5_clr_pkt", pkt_cnt, 16'd4);
    cyc(1'b1, 1'b0, 1'b1);
    repeat (7) cyc(1'b0, 1'b0, 1'b1);
    clr = 1'b1; cyc(1'b0, 1'b0, 1'b1); clr = 1'b0;
    chk("t5_set_wins", {15'd0, alarm}, 16'd1);
    chk("t5_hang2", hang_cnt, 16'd2);
    cyc(1'b1, 1'b1, 1'b1);
    chk("t5_pkt", pkt_cnt, 16'd5);
    clr = 1'b1; cyc(1'b0, 1'b0, 1'b1); clr = 1'b0;
    chk("t5_clr2", {15'd0, alarm}, 16'd0);

    // 4: long back-pressure does not count as a gap
    cyc(1'b1, 1'b0, 1'b1);
    repeat (100) cyc(1'b1, 1'b0, 1'b0);
    chk("t4_bp_alarm", {15'd0, alarm}, 16'd0);
    cyc(1'b1, 1'b1, 1'b1);
    chk("t4_bp_maxgap", max_gap, 16'd8);
    chk("t4_bp_pkt", pkt_cnt, 16'd6);

    // Back-pressure holds (not resets) a gap; gaps 3+5 reach threshold
    cyc(1'b1, 1'b0, 1'b1);
    repeat (3) cyc(1'b0, 1'b0, 1'b1);
    repeat (5) cyc(1'b1, 1'b0, 1'b0);
    repeat (4) cyc(1'b0, 1'b0, 1'b1);
    chk("hold_alarm_g7", {15'd0, alarm}, 16'd0);
    cyc(1'b0, 1'b0, 1'b1);
    chk("hold_alarm_g8", {15'd0, alarm}, 16'd1);
    chk("hold_hang", hang_cnt, 16'd3);
    // Second threshold gap in the same packet counts again; HUNG does not retrigger
    cyc(1'b1, 1'b0, 1'b1);
    chk("rehang_maxgap", max_gap, 16'd8);
    repeat (8) cyc(1'b0, 1'b0, 1'b1);
    chk("rehang_hang", hang_cnt, 16'd4);
    repeat (2) cyc(1'b0, 1'b0, 1'b1);
    chk("hung_no_retrig", hang_cnt, 16'd4);
    cyc(1'b1, 1'b1, 1'b1);
    chk("hung_maxgap10", max_gap, 16'd10);
    chk("hung_pkt", pkt_cnt, 16'd7);

    // 6: 4-bit counters saturate; reset mid-packet discards the packet
    rst4 = 1'b0;
    cyc4(1'b0, 1'b0, 1'b1);
    repeat (20) cyc4(1'b1, 1'b1, 1'b1);
    chk("t6_pkt_sat", {12'd0, pkt_cnt4}, 16'd15);
    cyc4(1'b1, 1'b0, 1'b1);
    repeat (20) cyc4(1'b0, 1'b0, 1'b1);
    chk("t6_hang", {12'd0, hang_cnt4}, 16'd1);
    cyc4(1'b1, 1'b1, 1'b1);
    chk("t6_gap_sat", {12'd0, max_gap4}, 16'd15);
    chk("t6_pkt_hold", {12'd0, pkt_cnt4}, 16'd15);
    chk("t6_alarm", {15'd0, alarm4}, 16'd1);
    cyc4(1'b1, 1'b0, 1'b1);
    repeat (3) cyc4(1'b0, 1'b0, 1'b1);
    rst4 = 1'b1; #1;
    chk("t6_rst_alarm", {15'd0, alarm4}, 16'd0);
    chk("t6_rst_pkt", {12'd0, pkt_cnt4}, 16'd0);
    chk("t6_rst_hang", {12'd0, hang_cnt4}, 16'd0);
    chk("t6_rst_maxgap", {12'd0, max_gap4}, 16'd0);
    @(posedge clk); #1;
    rst4 = 1'b0;
    repeat (10) cyc4(1'b0, 1'b0, 1'b1);
    chk("t6_post_idle_alarm", {15'd0, alarm4}, 16'd0);
    cyc4(1'b1, 1'b1, 1'b1);
    chk("t6_post_pkt", {12'd0, pkt_cnt4}, 16'd1);
    chk("t6_post_maxgap", {12'd0, max_gap4}, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
